// File: rtl/ttl_out_sequencer_if.sv
// Host/TTL-generator bundle for ttl_out_sequencer: step-table write port,
// run control, channel outputs and status.
interface ttl_out_sequencer_if #(
  parameter int STEPS  = 8,
  parameter int DUR_W  = 16,
  parameter int LOOP_W = 8
);
  localparam int AW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DUR_W+1:0]  cfg_data;
  logic [AW-1:0]     last_step;
  logic [LOOP_W-1:0] loop_cnt;
  logic              start;
  logic              abort;
  logic              branch_channel;
  logic              enable_channel;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_data, last_step, loop_cnt, start, abort,
    input  branch_channel, enable_channel, busy, done, step_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, last_step, loop_cnt, start, abort,
    output branch_channel, enable_channel, busy, done, step_idx
  );
endinterface

// File: rtl/ttl_out_sequencer.sv
// Step-table sequencer for the TTL generator's branch/enable controls.
// Define TTL_BBM_EN for a one-cycle break-before-make gap on branch changes.
module ttl_out_sequencer #(
  parameter int STEPS    = 8,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100,
  parameter int LOOP_W   = 8
) (
  input  logic                 clk_100Mz,
  input  logic                 rst,
  ttl_out_sequencer_if.slave   bus
);
  localparam int AW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [AW-1:0] LAST_MAX = AW'(STEPS - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);

  logic [DUR_W+1:0]  table_mem [STEPS];

  logic [1:0]        state;
  logic [AW-1:0]     step_idx;
  logic              branch_q;
  logic              enable_q;
  logic              busy_q;
  logic              done_q;
  logic              guard_q;
  logic [AW-1:0]     last_lat;
  logic              inf_lat;
  logic [LOOP_W-1:0] pass_cnt;
  logic [DUR_W-1:0]  dur_cnt;
  logic [PW-1:0]     pre_cnt;

  logic [AW-1:0]     nxt_idx;
  logic [DUR_W+1:0]  nxt_entry;
  logic [DUR_W-1:0]  nxt_dur;
  logic [DUR_W-1:0]  dur_load;
  logic              nxt_br;
  logic              nxt_en;
  logic              guard_now;
  logic              at_last;
  logic              wrap_ok;

  // NOTE: the step table has no reset; its contents are host-loaded and
  // keeping it out of the reset tree lets it map onto plain RAM/registers.
  always_ff @(posedge clk_100Mz) begin
    if (bus.cfg_we && state != ST_RUN && int'(bus.cfg_addr) < STEPS)
      table_mem[bus.cfg_addr] <= bus.cfg_data;
  end

  // Entry that becomes active at the next boundary: step 0 from IDLE or on wrap.
  always_comb begin
    nxt_idx = '0;
    if (state == ST_RUN && step_idx != last_lat)
      nxt_idx = step_idx + 1'b1;
  end

  assign nxt_entry = table_mem[nxt_idx];
  assign nxt_br    = nxt_entry[DUR_W+1];
  assign nxt_en    = nxt_entry[DUR_W];
  assign nxt_dur   = nxt_entry[DUR_W-1:0];
  assign dur_load  = (nxt_dur == '0) ? '0 : nxt_dur - 1'b1;
  assign at_last   = (step_idx == last_lat);
  assign wrap_ok   = inf_lat || (pass_cnt > LOOP_W'(1));

`ifdef TTL_BBM_EN
  // During a guard cycle enable_q is 0 but the running step is enabled.
  assign guard_now = (enable_q | guard_q) && nxt_en && (branch_q != nxt_br);
`else
  assign guard_now = 1'b0;
`endif

  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      branch_q <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      guard_q  <= 1'b0;
      last_lat <= '0;
      inf_lat  <= 1'b0;
      pass_cnt <= '0;
      dur_cnt  <= '0;
      pre_cnt  <= '0;
    end else if (bus.abort) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      branch_q <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      guard_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= ST_RUN;
            busy_q   <= 1'b1;
            step_idx <= '0;
            branch_q <= nxt_br;
            enable_q <= nxt_en;
            guard_q  <= 1'b0;
            dur_cnt  <= dur_load;
            pre_cnt  <= PRE_MAX;
            last_lat <= (int'(bus.last_step) >= STEPS) ? LAST_MAX : bus.last_step;
            inf_lat  <= (bus.loop_cnt == '0);
            pass_cnt <= bus.loop_cnt;
          end
        end

        ST_RUN: begin
          if (guard_q) begin
            enable_q <= 1'b1;
            guard_q  <= 1'b0;
          end
          if (pre_cnt != '0) begin
            pre_cnt <= pre_cnt - 1'b1;
          end else if (dur_cnt != '0) begin
            dur_cnt <= dur_cnt - 1'b1;
            pre_cnt <= PRE_MAX;
          end else if (!at_last || wrap_ok) begin
            if (at_last && !inf_lat)
              pass_cnt <= pass_cnt - 1'b1;
            step_idx <= nxt_idx;
            branch_q <= nxt_br;
            enable_q <= nxt_en & ~guard_now;
            guard_q  <= guard_now;
            dur_cnt  <= dur_load;
            pre_cnt  <= PRE_MAX;
          end else begin
            state    <= ST_DONE;
            step_idx <= '0;
            branch_q <= 1'b0;
            enable_q <= 1'b0;
            guard_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.branch_channel = branch_q;
  assign bus.enable_channel = enable_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.step_idx       = step_idx;
endmodule

// File: tb/tb_ttl_out_sequencer.sv
// Directed bench for ttl_out_sequencer with TICK_DIV=4; expected timing and
// outputs are hand-derived. Honours TTL_BBM_EN when the bench is built with it.
module tb_ttl_out_sequencer;
`ifdef TTL_BBM_EN
  localparam bit BBM = 1'b1;
`else
  localparam bit BBM = 1'b0;
`endif

  logic clk_100Mz;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ttl_out_sequencer_if #(.STEPS(8), .DUR_W(16), .LOOP_W(8)) bus ();

  ttl_out_sequencer #(
    .STEPS(8), .DUR_W(16), .TICK_DIV(4), .LOOP_W(8)
  ) dut (
    .clk_100Mz (clk_100Mz),
    .rst       (rst),
    .bus       (bus)
  );

  initial clk_100Mz = 1'b0;
  always #5 clk_100Mz = ~clk_100Mz;

  // {busy, done, branch, enable, step_idx}
  logic [6:0] obs;
  assign obs = {bus.busy, bus.done, bus.branch_channel, bus.enable_channel, bus.step_idx};

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Check one step held for n cycles; guard=1 expects enable low on its first cycle.
  task automatic hold(input string tag, input logic br, input logic en,
                      input logic [2:0] idx, input int n, input bit guard);
    for (int i = 0; i < n; i++) begin
      if (guard && i == 0) check(tag, obs, {2'b10, br, 1'b0, idx});
      else                 check(tag, obs, {2'b10, br, en, idx});
      @(negedge clk_100Mz);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, obs, 7'b0);
      @(negedge clk_100Mz);
    end
  endtask

  task automatic done_pulse(input string tag);
    check(tag, obs, 7'b01_0_0_000);
    @(negedge clk_100Mz);
  endtask

  task automatic write_entry(input logic [2:0] addr, input logic br, input logic en,
                             input logic [15:0] dur);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = {br, en, dur};
    @(negedge clk_100Mz);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic start_seq(input logic [2:0] last, input logic [7:0] loops);
    bus.last_step = last;
    bus.loop_cnt  = loops;
    bus.start     = 1'b1;
    @(negedge clk_100Mz);
    bus.start     = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.last_step = '0;
    bus.loop_cnt  = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    repeat (2) @(negedge clk_100Mz);
    rst = 1'b0;
    idle("reset", 2);

    // Single pass of the three-step table: 8 + 4 + 12 cycles, then done.
    write_entry(3'd0, 1'b1, 1'b1, 16'd2);
    write_entry(3'd1, 1'b0, 1'b1, 16'd1);
    write_entry(3'd2, 1'b0, 1'b0, 16'd3);
    start_seq(3'd2, 8'd1);
    hold("t1_s0", 1'b1, 1'b1, 3'd0, 8, 1'b0);
    hold("t1_s1", 1'b0, 1'b1, 3'd1, 4, BBM);
    hold("t1_s2", 1'b0, 1'b0, 3'd2, 12, 1'b0);
    done_pulse("t1_done");
    idle("t1_idle", 2);

    // Three passes; the 2->0 wrap has enable low on the old step, so no guard.
    start_seq(3'd2, 8'd3);
    for (int p = 0; p < 3; p++) begin
      hold("t2_s0", 1'b1, 1'b1, 3'd0, 8, 1'b0);
      hold("t2_s1", 1'b0, 1'b1, 3'd1, 4, BBM);
      hold("t2_s2", 1'b0, 1'b0, 3'd2, 12, 1'b0);
    end
    done_pulse("t2_done");
    idle("t2_idle", 2);

    // Infinite loop, aborted 50 cycles into RUN (pass 3, step 0).
    start_seq(3'd2, 8'd0);
    repeat (50) @(negedge clk_100Mz);
    check("t3_pre_abort", obs, {2'b10, 1'b1, 1'b1, 3'd0});
    bus.abort = 1'b1;
    @(negedge clk_100Mz);
    bus.abort = 1'b0;
    idle("t3_abort", 30);

    // Table write while running is ignored; a replay shows the original entry 0.
    start_seq(3'd2, 8'd1);
    check("t4_run", obs, {2'b10, 1'b1, 1'b1, 3'd0});
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_data = {1'b0, 1'b0, 16'd5};
    @(negedge clk_100Mz);
    bus.cfg_we   = 1'b0;
    hold("t4_s0", 1'b1, 1'b1, 3'd0, 7, 1'b0);
    hold("t4_s1", 1'b0, 1'b1, 3'd1, 4, BBM);
    hold("t4_s2", 1'b0, 1'b0, 3'd2, 12, 1'b0);
    done_pulse("t4_done");
    start_seq(3'd2, 8'd1);
    hold("t4_reread_s0", 1'b1, 1'b1, 3'd0, 8, 1'b0);
    hold("t4_reread_s1", 1'b0, 1'b1, 3'd1, 4, BBM);
    bus.abort = 1'b1;
    @(negedge clk_100Mz);
    bus.abort = 1'b0;
    idle("t4_abort", 3);

    // start and abort together in IDLE: abort wins.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk_100Mz);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    idle("t4_start_abort", 5);

    // Asynchronous reset mid-step clears outputs before the next clock edge.
    start_seq(3'd2, 8'd1);
    hold("t5_s0", 1'b1, 1'b1, 3'd0, 3, 1'b0);
    #2 rst = 1'b1;
    #1 check("t5_async_rst", obs, 7'b0);
    @(negedge clk_100Mz);
    rst = 1'b0;
    idle("t5_idle", 2);

    // D=0 is held like D=1.
    write_entry(3'd0, 1'b1, 1'b1, 16'd0);
    write_entry(3'd1, 1'b0, 1'b1, 16'd1);
    start_seq(3'd1, 8'd1);
    hold("t6_d0", 1'b1, 1'b1, 3'd0, 4, 1'b0);
    hold("t6_d1", 1'b0, 1'b1, 3'd1, 4, BBM);
    done_pulse("t6_done");
    idle("t6_idle", 2);

    // Break-before-make case: step 1 is (0,0) once then (0,1) when enabled.
    write_entry(3'd0, 1'b1, 1'b1, 16'd2);
    write_entry(3'd1, 1'b0, 1'b1, 16'd2);
    start_seq(3'd1, 8'd1);
    hold("t7_s0", 1'b1, 1'b1, 3'd0, 8, 1'b0);
    hold("t7_s1", 1'b0, 1'b1, 3'd1, 8, BBM);
    done_pulse("t7_done");
    idle("t7_idle", 2);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule

// File: doc/ttl_out_sequencer.md
Name: ttl_out_sequencer

Overview:
- Programmable time-sequencer driving the branch_channel / enable_channel controls of the TTL output generator in the check unit.
- Host loads a small step table; each step holds {branch, enable, duration}.
- On start, the block plays the table for a set number of loops, then returns to idle with both outputs low.

Parameters:
- STEPS, 8: number of table entries; address width AW = $clog2(STEPS).
- DUR_W, 16: step duration width, in ticks.
- TICK_DIV, 100: clk_100Mz cycles per tick (100 gives a 1 us tick).
- LOOP_W, 8: loop counter width.

Ports:
- clk_100Mz  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  AW  table write address.
- cfg_data  in  DUR_W+2  {branch, enable, duration[DUR_W-1:0]}.
- last_step  in  AW  index of final step in the sequence.
- loop_cnt  in  LOOP_W  number of passes; 0 means run until abort.
- start  in  1  start request, single-cycle level sample.
- abort  in  1  stop request.
- branch_channel  out  1  to TTL generator: output select.
- enable_channel  out  1  to TTL generator: output enable.
- busy  out  1  sequence running.
- done  out  1  one-cycle pulse at normal completion.
- step_idx  out  AW  current step index.

Behaviour:
- Reset: asynchronous, active-high, one clock. All outputs 0, state IDLE, table contents undefined.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs 0.
  - cfg_we writes cfg_data to entry cfg_addr on the clock edge.
  - start=1 sampled at cycle t: at t+1 state is RUN, busy=1, step_idx=0, branch/enable = entry 0.
  - last_step and loop_cnt are latched at start.
- RUN:
  - The tick prescaler restarts at each step entry.
  - A step with duration D is held exactly max(D,1)*TICK_DIV cycles; D=0 is treated as 1.
  - At step end, if step_idx < last_step: go to step_idx+1.
  - At step end, if step_idx == last_step:
    - latched loop_cnt==0 (infinite), or passes remaining > 1: wrap to step 0 and decrement passes remaining.
    - otherwise: go to DONE.
  - Outputs change only on step boundaries. No cycle with stale or zero outputs between steps, except as defined under TTL_BBM_EN.
- DONE: lasts one cycle. done=1, busy=0, outputs 0, step_idx=0. Next state is IDLE.
- abort:
  - In any state: next cycle IDLE, outputs 0, busy=0, no done pulse.
  - abort with start in the same cycle: abort wins, and start is dropped.
- Ignored inputs:
  - cfg_we while busy is ignored; the table is unchanged.
  - start while busy is ignored.
  - last_step >= STEPS is clamped to STEPS-1 at latch.
- Counters: duration counter is DUR_W bits, prescaler is $clog2(TICK_DIV) bits, pass counter is LOOP_W bits. None of them wraps silently; each is reloaded at each boundary.

Optional Feature:
- Macro: TTL_BBM_EN (break-before-make).
- Defined:
  - When consecutive steps, including the last-to-0 wrap, differ in branch and both have enable=1, enable_channel is forced 0 for the first cycle of the new step.
  - branch_channel switches in that same cycle.
  - The guard cycle counts inside the new step's duration, so total step timing is unchanged.
- Undefined: branch and enable switch together on the boundary cycle, with no guard cycle.

Test Plan:
All cases use TICK_DIV=4.
- Load 3 steps {1,1,2},{0,1,1},{0,0,3}; last_step=2, loop_cnt=1; pulse start.
  - busy rises next cycle.
  - Outputs (1,1) for 8 cycles, (0,1) for 4, (0,0) for 12.
  - Then done pulses for exactly 1 cycle and busy=0.
- Same table with loop_cnt=3.
  - Exactly 3 passes (72 cycles of RUN), then one done pulse.
  - step_idx sequence is 0,1,2 repeated ×3.
- loop_cnt=0; abort asserted 50 cycles into RUN.
  - Next cycle outputs 0 and busy=0.
  - No done pulse.
- Step with D=0 → held 4 cycles. cfg_we during RUN → table readback after idle is unchanged. start and abort in the same IDLE cycle → stays IDLE.
- rst asserted mid-step asynchronously → outputs 0 immediately, without waiting for a clock edge.
- TTL_BBM_EN defined, steps {1,1,2},{0,1,2}:
  - First cycle of step 1 shows (0,0), then (0,1) for 7 cycles.
  - With the macro undefined: (0,1) for all 8 cycles.
